// File: rtl/wb_write_merge_if.sv
// Bundles the register-file write merger's bus signals: pipeline writeback,
// multiply-unit results, the merged register-file write port and the pending mask.
interface wb_write_merge_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              pipe_we;
  logic [3:0]        pipe_wa;
  logic [31:0]       pipe_wd;
  logic              mul_valid;
  logic [3:0]        mul_wa;
  logic [31:0]       mul_wd;
  logic              mul_ready;
  logic              we3;
  logic [3:0]        wa3;
  logic [31:0]       wd3;
  logic [14:0]       pending;
  logic [PTR_W:0]    count;

  modport master (
    output pipe_we, pipe_wa, pipe_wd, mul_valid, mul_wa, mul_wd,
    input  mul_ready, we3, wa3, wd3, pending, count
  );

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, mul_valid, mul_wa, mul_wd,
    output mul_ready, we3, wa3, wd3, pending, count
  );
endinterface

// File: rtl/wb_write_merge.sv
// Merges pipeline writebacks and queued multiply results onto the single
// register-file write port; pipeline writes always win, the queue drains on idle cycles.
module wb_write_merge #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  wb_write_merge_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [3:0]     PC_REG   = 4'd15;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] occ_q;
  logic [DEPTH-1:0] live_q;
  logic [3:0]       wa_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  logic             we3_q;
  logic [3:0]       wa3_q;
  logic [31:0]      wd3_q;

  logic             full;
  logic             pipe_ok;
  logic             push;
  logic             pop;
  logic             push_squashed;
  logic [14:0]      pend;

  assign full          = (count_q == FULL_CNT);
  assign pipe_ok       = bus.pipe_we && (bus.pipe_wa != PC_REG);
  // r15 results are accepted (handshake completes) but never stored
  assign push          = bus.mul_valid && !full && (bus.mul_wa != PC_REG);
  assign pop           = !bus.pipe_we && (count_q != '0);
  assign push_squashed = pipe_ok && (bus.mul_wa == bus.pipe_wa);

  always_comb begin
    pend = '0;
    for (int r = 0; r < 15; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (occ_q[e] && live_q[e] && (wa_q[e] == 4'(r))) pend[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q   <= '0;
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // a younger pipeline write makes older queued writes to the same register dead
      for (int e = 0; e < DEPTH; e++) begin
        if (pipe_ok && (wa_q[e] == bus.pipe_wa)) live_q[e] <= 1'b0;
      end
      if (push) begin
        occ_q[tail_q]  <= 1'b1;
        live_q[tail_q] <= !push_squashed;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        occ_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[tail_q] <= bus.mul_wa;
      wd_q[tail_q] <= bus.mul_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else if (bus.pipe_we) begin
      we3_q <= pipe_ok;
      if (pipe_ok) begin
        wa3_q <= bus.pipe_wa;
        wd3_q <= bus.pipe_wd;
      end
    end else if (pop && live_q[head_q]) begin
      we3_q <= 1'b1;
      wa3_q <= wa_q[head_q];
      wd3_q <= wd_q[head_q];
    end else begin
      we3_q <= 1'b0;
    end
  end

  assign bus.mul_ready = !full;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.pending   = pend;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_wb_write_merge.sv
// Directed bench for the writeback merger: passthrough, queue/drain, backpressure,
// squash, r15 filtering and mid-drain reset, each with hand-computed expectations.
module tb_wb_write_merge;
  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  wb_write_merge_if #(.DEPTH(4)) bus ();

  wb_write_merge #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [3:0] pwa, input logic [31:0] pwd,
                       input logic mv, input logic [3:0] mwa, input logic [31:0] mwd);
    bus.pipe_we   = pwe;
    bus.pipe_wa   = pwa;
    bus.pipe_wd   = pwd;
    bus.mul_valid = mv;
    bus.mul_wa    = mwa;
    bus.mul_wd    = mwd;
  endtask

  task automatic test_reset();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    reset = 1'b1;
    repeat (3) cyc();
    nvec++; if (bus.we3 !== 1'b0) begin nerr++; $display("FAIL reset_we3 got %b exp 0", bus.we3); end
    nvec++; if (bus.wa3 !== 4'd0 || bus.wd3 !== 32'd0) begin nerr++; $display("FAIL reset_wa3wd3 got %0d/%h exp 0/0", bus.wa3, bus.wd3); end
    nvec++; if (bus.count !== 3'd0 || bus.pending !== 15'd0) begin nerr++; $display("FAIL reset_count_pend got %0d/%h exp 0/0", bus.count, bus.pending); end
    nvec++; if (bus.mul_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", bus.mul_ready); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_passthrough();
    drive(1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd3 || bus.wd3 !== 32'h1234_5678) begin
      nerr++; $display("FAIL pass_write got %b/%0d/%h exp 1/3/12345678", bus.we3, bus.wa3, bus.wd3); end
    nvec++; if (bus.count !== 3'd0) begin nerr++; $display("FAIL pass_count got %0d exp 0", bus.count); end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b0 || bus.wa3 !== 4'd3) begin nerr++; $display("FAIL pass_idle got %b/%0d exp 0/3", bus.we3, bus.wa3); end
  endtask

  task automatic test_queue_drain();
    drive(1'b1, 4'd1, 32'h100, 1'b1, 4'd5, 32'hA);
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd1 || bus.pending !== 15'h0020 || bus.count !== 3'd1) begin
      nerr++; $display("FAIL qd_c1 got we%b wa%0d pend%h cnt%0d exp 1/1/0020/1", bus.we3, bus.wa3, bus.pending, bus.count); end
    drive(1'b1, 4'd2, 32'h200, 1'b1, 4'd6, 32'hB);
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd2 || bus.pending !== 15'h0060 || bus.count !== 3'd2) begin
      nerr++; $display("FAIL qd_c2 got we%b wa%0d pend%h cnt%0d exp 1/2/0060/2", bus.we3, bus.wa3, bus.pending, bus.count); end
    drive(1'b1, 4'd3, 32'h300, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd3 || bus.wd3 !== 32'h300 || bus.pending !== 15'h0060) begin
      nerr++; $display("FAIL qd_c3 got we%b wa%0d wd%h pend%h exp 1/3/300/0060", bus.we3, bus.wa3, bus.wd3, bus.pending); end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd5 || bus.wd3 !== 32'hA || bus.count !== 3'd1 || bus.pending !== 15'h0040) begin
      nerr++; $display("FAIL qd_pop1 got we%b wa%0d wd%h cnt%0d pend%h exp 1/5/a/1/0040", bus.we3, bus.wa3, bus.wd3, bus.count, bus.pending); end
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd6 || bus.wd3 !== 32'hB || bus.count !== 3'd0 || bus.pending !== 15'h0) begin
      nerr++; $display("FAIL qd_pop2 got we%b wa%0d wd%h cnt%0d pend%h exp 1/6/b/0/0000", bus.we3, bus.wa3, bus.wd3, bus.count, bus.pending); end
    cyc();
    nvec++; if (bus.we3 !== 1'b0 || bus.wa3 !== 4'd6) begin nerr++; $display("FAIL qd_after got %b/%0d exp 0/6", bus.we3, bus.wa3); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd0, 32'd0, 1'b1, 4'(8 + i), 32'hC0 + i);
      cyc();
    end
    nvec++; if (bus.count !== 3'd4 || bus.mul_ready !== 1'b0) begin
      nerr++; $display("FAIL full_state got cnt%0d rdy%b exp 4/0", bus.count, bus.mul_ready); end
    drive(1'b1, 4'd0, 32'd0, 1'b1, 4'd12, 32'hEE);
    cyc();
    nvec++; if (bus.count !== 3'd4 || bus.pending !== 15'h0F00) begin
      nerr++; $display("FAIL full_reject got cnt%0d pend%h exp 4/0f00", bus.count, bus.pending); end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'(8 + i) || bus.wd3 !== 32'hC0 + i || bus.count !== 3'(3 - i)) begin
        nerr++; $display("FAIL full_drain%0d got we%b wa%0d wd%h cnt%0d exp 1/%0d/%h/%0d",
                         i, bus.we3, bus.wa3, bus.wd3, bus.count, 8 + i, 32'hC0 + i, 3 - i); end
    end
    cyc();
    nvec++; if (bus.we3 !== 1'b0) begin nerr++; $display("FAIL full_extra got %b exp 0", bus.we3); end
    drive(1'b1, 4'd0, 32'd0, 1'b1, 4'd13, 32'hD0);
    cyc();
    drive(1'b1, 4'd0, 32'd0, 1'b1, 4'd14, 32'hD1);
    cyc();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd13 || bus.wd3 !== 32'hD0) begin
      nerr++; $display("FAIL refill1 got %b/%0d/%h exp 1/13/d0", bus.we3, bus.wa3, bus.wd3); end
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd14 || bus.wd3 !== 32'hD1 || bus.count !== 3'd0) begin
      nerr++; $display("FAIL refill2 got %b/%0d/%h cnt%0d exp 1/14/d1/0", bus.we3, bus.wa3, bus.wd3, bus.count); end
  endtask

  task automatic test_squash();
    drive(1'b1, 4'd0, 32'd0, 1'b1, 4'd7, 32'h11);
    cyc();
    nvec++; if (bus.pending !== 15'h0080 || bus.count !== 3'd1) begin
      nerr++; $display("FAIL sq_queued got pend%h cnt%0d exp 0080/1", bus.pending, bus.count); end
    drive(1'b1, 4'd7, 32'h22, 1'b1, 4'd7, 32'h33);
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd7 || bus.wd3 !== 32'h22) begin
      nerr++; $display("FAIL sq_pipe got %b/%0d/%h exp 1/7/22", bus.we3, bus.wa3, bus.wd3); end
    nvec++; if (bus.pending !== 15'h0 || bus.count !== 3'd2) begin
      nerr++; $display("FAIL sq_pend got pend%h cnt%0d exp 0000/2", bus.pending, bus.count); end
    drive(1'b1, 4'd0, 32'd0, 1'b1, 4'd9, 32'h44);
    cyc();
    nvec++; if (bus.pending !== 15'h0200 || bus.count !== 3'd3) begin
      nerr++; $display("FAIL sq_live got pend%h cnt%0d exp 0200/3", bus.pending, bus.count); end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b0 || bus.wa3 !== 4'd0 || bus.count !== 3'd2) begin
      nerr++; $display("FAIL sq_drain1 got we%b wa%0d cnt%0d exp 0/0/2", bus.we3, bus.wa3, bus.count); end
    cyc();
    nvec++; if (bus.we3 !== 1'b0 || bus.count !== 3'd1) begin
      nerr++; $display("FAIL sq_drain2 got we%b cnt%0d exp 0/1", bus.we3, bus.count); end
    cyc();
    nvec++; if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd9 || bus.wd3 !== 32'h44 || bus.count !== 3'd0) begin
      nerr++; $display("FAIL sq_drain3 got %b/%0d/%h cnt%0d exp 1/9/44/0", bus.we3, bus.wa3, bus.wd3, bus.count); end
  endtask

  task automatic test_r15();
    drive(1'b1, 4'd15, 32'hDEAD, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b0) begin nerr++; $display("FAIL r15_pipe got %b exp 0", bus.we3); end
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'hBEEF);
    #1;
    nvec++; if (bus.mul_ready !== 1'b1) begin nerr++; $display("FAIL r15_ready got %b exp 1", bus.mul_ready); end
    cyc();
    nvec++; if (bus.count !== 3'd0 || bus.pending !== 15'h0) begin
      nerr++; $display("FAIL r15_mul got cnt%0d pend%h exp 0/0000", bus.count, bus.pending); end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    cyc();
    nvec++; if (bus.we3 !== 1'b0) begin nerr++; $display("FAIL r15_nowrite got %b exp 0", bus.we3); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd0, 32'h55, 1'b1, 4'(1 + i), 32'h70 + i);
      cyc();
    end
    nvec++; if (bus.count !== 3'd3 || bus.we3 !== 1'b1) begin
      nerr++; $display("FAIL rstm_pre got cnt%0d we%b exp 3/1", bus.count, bus.we3); end
    #2;
    reset = 1'b1;
    #1;
    nvec++; if (bus.we3 !== 1'b0 || bus.count !== 3'd0 || bus.pending !== 15'h0 || bus.mul_ready !== 1'b1) begin
      nerr++; $display("FAIL rstm_async got we%b cnt%0d pend%h rdy%b exp 0/0/0000/1", bus.we3, bus.count, bus.pending, bus.mul_ready); end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      nvec++; if (bus.we3 !== 1'b0 || bus.count !== 3'd0) begin
        nerr++; $display("FAIL rstm_after%0d got we%b cnt%0d exp 0/0", i, bus.we3, bus.count); end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_passthrough();
    test_queue_drain();
    test_full();
    test_squash();
    test_r15();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
